tile_pin_scheduler: RTL and testbench
=====================================

// Module: tile_pin_scheduler
// PURPOSE
//   Time-shares the single 8-bit ui_in/uo_out pin pair among N_TILES microtile designs.
//   - Grants exactly one tile at a time.
//   - Routes ui_in to the granted tile and that tile's output to uo_out.
//   - Rotates the grant round-robin (auto mode) or on an explicit load (manual mode).
//   - Inserts a break-before-make guard on every switch-over.
// PARAMETERS
//   N_TILES  4   number of tiles sharing the pins (2..16)
//   W        8   pin bus width
//   DWELL    16  auto-mode cycles a tile holds the pins before rotation (>=2)
//   GUARD    2   blanking cycles between tiles (>=1)
// PORTS
//   clk           in   1          clock
//   rst           in   1          asynchronous reset, active-high
//   ui_in         in   W          shared input pins
//   uo_out        out  W          shared output pins (registered)
//   tile_uo       in   N_TILES*W  tile outputs; tile k at [k*W +: W]
//   tile_ui       out  N_TILES*W  tile inputs; ungranted slices forced to 0
//   tile_req      in   N_TILES    tile requests the pins
//   tile_gnt      out  N_TILES    one-hot grant (registered)
//   auto_en       in   1          1 = round-robin rotation, 0 = manual only
//   man_sel       in   SELW       manual target index; SELW = $clog2(N_TILES)
//   man_load      in   1          one-cycle strobe: switch to man_sel
//   cur_tile      out  SELW       index of the current or pending tile
//   switch_pulse  out  1          1-cycle pulse on entering ACTIVE
// BEHAVIOUR
//   Reset: state=IDLE; cur_tile=0; tile_gnt=0; uo_out=0; switch_pulse=0; dwell=0.
//     Reset is asynchronous and applies mid-operation.
//   FSM states: IDLE, GUARD, ACTIVE.
//   IDLE
//     - tile_gnt=0, uo_out=0.
//     - man_load -> GUARD with target man_sel (tile_req is ignored).
//     - else if auto_en and |tile_req -> GUARD with target = rr_next.
//   GUARD
//     - tile_gnt=0, uo_out=0.
//     - The guard counter counts GUARD cycles, then the FSM enters ACTIVE.
//     - On entering ACTIVE: grant the target; switch_pulse=1 for 1 cycle; dwell=0.
//     - man_load during GUARD replaces the target and restarts the guard count.
//   ACTIVE
//     - tile_gnt = onehot(cur_tile).
//     - uo_out <= tile_uo[cur_tile], 1-cycle latency.
//     - tile_ui[cur_tile] = ui_in, combinational and gated by the registered grant.
//     - dwell increments and saturates at DWELL-1.
//     - Priority: man_load > request drop > dwell expiry.
//     - man_load with man_sel != cur_tile -> GUARD with target man_sel.
//       man_load with man_sel == cur_tile is ignored.
//     - auto_en and !tile_req[cur_tile] -> GUARD with rr_next.
//       If no other requester exists -> IDLE.
//     - auto_en, dwell==DWELL-1, and another requester exists -> GUARD with rr_next.
//       If no other requester exists, keep the grant; dwell stays saturated.
//     - auto_en=0: the grant is held indefinitely; tile_req is ignored.
//   rr_next: first set tile_req bit searching from cur_tile+1 upward.
//     The search wraps modulo N_TILES, and cur_tile is considered last.
//   cur_tile updates when GUARD is entered (it shows the pending target).
//   Out-of-range man_sel (>= N_TILES) is ignored.
// CONFIGURATION
//   Macro TILE_SCHED_STATUS_EN.
//   - Defined: adds output status[7:0] = {state[1:0], switch_cnt[5:0]}.
//     switch_cnt is a wrapping count of ACTIVE entries; reset value 0.
//   - Undefined: no status port and no counter logic.
//     All other behaviour is identical.
// STRUCTURE
//   Package tile_sched_pkg:
//   - state enum {IDLE=0, GUARD=1, ACTIVE=2}
//   - SELW/counter-width helper constants
//   Sub-module tile_rr_picker: combinational (req, cur) -> (next, found).
//   The FSM, counters and pin muxing stay in tile_pin_scheduler.
// TESTING (N_TILES=4, DWELL=16, GUARD=2)
//   1. Reset release, auto_en=1, tile_req=4'b0101.
//      -> 2 blanked cycles, then tile_gnt=0001 with switch_pulse.
//      -> After 16 cycles: GUARD, then tile_gnt=0100.
//   2. In ACTIVE on tile 0, tile_req drops to 4'b1000.
//      -> Next cycle GUARD; uo_out=0 for 2 cycles; then tile_gnt=1000.
//   3. auto_en=0, man_sel=2, man_load.
//      -> tile_gnt=0100 after guard; held for 100 cycles despite tile_req=1111.
//   4. man_load sel=1, then man_load sel=3 in the 2nd guard cycle.
//      -> Guard restarts; final tile_gnt=1000; tile 1 is never granted.
//   5. Granted tile 2 drives 8'hA5, ui_in=8'h3C.
//      -> uo_out=8'hA5 one cycle later.
//      -> tile_ui slice 2 = 8'h3C; all other slices 0.
//   6. Assert rst while ACTIVE.
//      -> tile_gnt=0 and uo_out=0 immediately (async); IDLE after release.

Source files
------------

// File: rtl/tile_sched_pkg.sv
// Shared types and width helpers for the tile pin scheduler.
package tile_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int SWITCH_CNT_W = 6;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_rr_picker.sv
// Round-robin search: first requesting tile after cur_i, wrapping, cur_i itself last.
module tile_rr_picker
    import tile_sched_pkg::*;
#(
    parameter int N_TILES = 4,
    parameter int SELW    = cnt_w(N_TILES)
) (
    input  logic [N_TILES-1:0] req_i,
    input  logic [SELW-1:0]    cur_i,
    output logic [SELW-1:0]    next_o,
    output logic               found_o
);

    always_comb begin
        next_o  = cur_i;
        found_o = 1'b0;
        for (int i = 1; i <= N_TILES; i++) begin
            if (!found_o && req_i[(int'(cur_i) + i) % N_TILES]) begin
                found_o = 1'b1;
                next_o  = SELW'((int'(cur_i) + i) % N_TILES);
            end
        end
    end

endmodule

// File: rtl/tile_pin_scheduler.sv
// Time-shares one ui_in/uo_out pin pair among N_TILES tiles with break-before-make guarding.
// Define TILE_SCHED_STATUS_EN to add the status port {state, wrapping ACTIVE-entry count}.
module tile_pin_scheduler
    import tile_sched_pkg::*;
#(
    parameter int N_TILES = 4,
    parameter int W       = 8,
    parameter int DWELL   = 16,
    parameter int GUARD   = 2,
    localparam int SELW   = cnt_w(N_TILES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           ui_in,
    output logic [W-1:0]           uo_out,
    input  logic [N_TILES*W-1:0]   tile_uo,
    output logic [N_TILES*W-1:0]   tile_ui,
    input  logic [N_TILES-1:0]     tile_req,
    output logic [N_TILES-1:0]     tile_gnt,
    input  logic                   auto_en,
    input  logic [SELW-1:0]        man_sel,
    input  logic                   man_load,
    output logic [SELW-1:0]        cur_tile,
    output logic                   switch_pulse
`ifdef TILE_SCHED_STATUS_EN
    ,
    output logic [7:0]             status
`endif
);

    localparam int DW = cnt_w(DWELL);
    localparam int GW = cnt_w(GUARD);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    state_t              state_q, state_d;
    logic [SELW-1:0]     cur_q, cur_d;
    logic [GW-1:0]       gcnt_q, gcnt_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [N_TILES-1:0]  gnt_q, gnt_d;
    logic [W-1:0]        uo_q, uo_d;
    logic                pulse_q, pulse_d;

    logic [SELW-1:0]     pick_cur;
    logic [SELW-1:0]     rr_next;
    logic                rr_found;
    logic                other_req;
    logic                man_ok;

    // From IDLE nothing is granted, so the search starts at cur_q itself rather than after it.
    assign pick_cur = (state_q != ST_IDLE) ? cur_q
                    : (cur_q == '0) ? SELW'(N_TILES - 1) : cur_q - SELW'(1);

    tile_rr_picker #(
        .N_TILES (N_TILES),
        .SELW    (SELW)
    ) u_picker (
        .req_i   (tile_req),
        .cur_i   (pick_cur),
        .next_o  (rr_next),
        .found_o (rr_found)
    );

    assign other_req = rr_found && (rr_next != cur_q);
    assign man_ok    = man_load && (int'(man_sel) < N_TILES);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        gcnt_d  = gcnt_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (man_ok) begin
                    state_d = ST_GUARD;
                    cur_d   = man_sel;
                    gcnt_d  = '0;
                end else if (auto_en && rr_found) begin
                    state_d = ST_GUARD;
                    cur_d   = rr_next;
                    gcnt_d  = '0;
                end
            end
            ST_GUARD: begin
                if (man_ok) begin
                    cur_d  = man_sel;
                    gcnt_d = '0;
                end else if (gcnt_q == GUARD_LAST) begin
                    state_d = ST_ACTIVE;
                    dwell_d = '0;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            ST_ACTIVE: begin
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + DW'(1);
                end
                if (man_ok && (man_sel != cur_q)) begin
                    state_d = ST_GUARD;
                    cur_d   = man_sel;
                    gcnt_d  = '0;
                end else if (auto_en && !tile_req[cur_q]) begin
                    if (rr_found) begin
                        state_d = ST_GUARD;
                        cur_d   = rr_next;
                        gcnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (auto_en && (dwell_q == DWELL_LAST) && other_req) begin
                    state_d = ST_GUARD;
                    cur_d   = rr_next;
                    gcnt_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first ACTIVE cycle and any cycle leaving ACTIVE present zeros on uo_out.
    always_comb begin
        gnt_d   = (state_d == ST_ACTIVE) ? (N_TILES'(1) << cur_d) : '0;
        uo_d    = ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE)) ? tile_uo[cur_q*W +: W] : '0;
        pulse_d = (state_q == ST_GUARD) && (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            gcnt_q  <= '0;
            dwell_q <= '0;
            gnt_q   <= '0;
            uo_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            gcnt_q  <= gcnt_d;
            dwell_q <= dwell_d;
            gnt_q   <= gnt_d;
            uo_q    <= uo_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        tile_ui = '0;
        for (int k = 0; k < N_TILES; k++) begin
            tile_ui[k*W +: W] = gnt_q[k] ? ui_in : '0;
        end
    end

    assign uo_out       = uo_q;
    assign tile_gnt     = gnt_q;
    assign cur_tile     = cur_q;
    assign switch_pulse = pulse_q;

`ifdef TILE_SCHED_STATUS_EN
    logic [SWITCH_CNT_W-1:0] sw_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cnt_q <= '0;
        end else if (pulse_d) begin
            sw_cnt_q <= sw_cnt_q + SWITCH_CNT_W'(1);
        end
    end

    assign status = {state_q, sw_cnt_q};
`endif

endmodule

// File: tb/tb_tile_pin_scheduler.sv
// Directed bench for tile_pin_scheduler (N_TILES=4, W=8, DWELL=16, GUARD=2).
module tb_tile_pin_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uo_out;
    logic [31:0] tile_uo = 32'h13121110;
    logic [31:0] tile_ui;
    logic [3:0]  tile_req = 4'b0101;
    logic [3:0]  tile_gnt;
    logic        auto_en = 1'b1;
    logic [1:0]  man_sel = 2'd0;
    logic        man_load = 1'b0;
    logic [1:0]  cur_tile;
    logic        switch_pulse;

    int n_cmp = 0;
    int n_err = 0;

    tile_pin_scheduler #(
        .N_TILES (4),
        .W       (8),
        .DWELL   (16),
        .GUARD   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ui_in        (ui_in),
        .uo_out       (uo_out),
        .tile_uo      (tile_uo),
        .tile_ui      (tile_ui),
        .tile_req     (tile_req),
        .tile_gnt     (tile_gnt),
        .auto_en      (auto_en),
        .man_sel      (man_sel),
        .man_load     (man_load),
        .cur_tile     (cur_tile),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        auto_en;
        logic [3:0]  req;
        logic [1:0]  sel;
        logic        load;
        logic [3:0]  gnt;
        logic [1:0]  cur;
        logic        pulse;
        logic [7:0]  uo;
        logic [31:0] tui;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Per-cycle table, applied from IDLE; tile_uo=13121110, ui_in=5A.
        tbl[0]  = '{1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 32'h00000000};
        tbl[1]  = '{1'b0, 4'b1111, 2'd1, 1'b1, 4'b0000, 2'd1, 1'b0, 8'h00, 32'h00000000};
        tbl[2]  = '{1'b0, 4'b1111, 2'd1, 1'b0, 4'b0000, 2'd1, 1'b0, 8'h00, 32'h00000000};
        tbl[3]  = '{1'b0, 4'b1111, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b1, 8'h00, 32'h00005A00};
        tbl[4]  = '{1'b0, 4'b1111, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b0, 8'h11, 32'h00005A00};
        tbl[5]  = '{1'b0, 4'b1111, 2'd1, 1'b1, 4'b0010, 2'd1, 1'b0, 8'h11, 32'h00005A00};
        tbl[6]  = '{1'b1, 4'b0010, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b0, 8'h11, 32'h00005A00};
        tbl[7]  = '{1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000, 2'd1, 1'b0, 8'h00, 32'h00000000};
        tbl[8]  = '{1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000, 2'd1, 1'b0, 8'h00, 32'h00000000};
        tbl[9]  = '{1'b1, 4'b0001, 2'd1, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 32'h00000000};
        tbl[10] = '{1'b1, 4'b0001, 2'd1, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00, 32'h00000000};
        tbl[11] = '{1'b1, 4'b0001, 2'd1, 1'b0, 4'b0001, 2'd0, 1'b1, 8'h00, 32'h0000005A};
        tbl[12] = '{1'b1, 4'b0001, 2'd3, 1'b1, 4'b0000, 2'd3, 1'b0, 8'h00, 32'h00000000};

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst.gnt", 32'(tile_gnt), 32'h0);
        chk("rst.uo", 32'(uo_out), 32'h0);
        chk("rst.cur", 32'(cur_tile), 32'h0);
        chk("rst.pulse", 32'(switch_pulse), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: auto rotation 0 -> 2 after the dwell
        tick();
        chk("t1.guard1.gnt", 32'(tile_gnt), 32'h0);
        chk("t1.guard1.cur", 32'(cur_tile), 32'h0);
        tick();
        chk("t1.guard2.gnt", 32'(tile_gnt), 32'h0);
        tick();
        chk("t1.act.gnt", 32'(tile_gnt), 32'h1);
        chk("t1.act.pulse", 32'(switch_pulse), 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("t1.dwell%0d.gnt", i), 32'(tile_gnt), 32'h1);
            if (i == 0) chk("t1.uo", 32'(uo_out), 32'h10);
        end
        tick();
        chk("t1.rot.gnt", 32'(tile_gnt), 32'h0);
        chk("t1.rot.cur", 32'(cur_tile), 32'h2);
        chk("t1.rot.uo", 32'(uo_out), 32'h0);
        tick();
        chk("t1.rot2.gnt", 32'(tile_gnt), 32'h0);
        tick();
        chk("t1.act2.gnt", 32'(tile_gnt), 32'h4);
        chk("t1.act2.pulse", 32'(switch_pulse), 32'h1);
        tick();
        chk("t1.act2.uo", 32'(uo_out), 32'h12);

        // 2: request drop on tile 0 moves to tile 3
        tile_req = 4'b0001;
        do_reset();
        repeat (5) tick();
        chk("t2.pre.gnt", 32'(tile_gnt), 32'h1);
        tile_req = 4'b1000;
        tick();
        chk("t2.g1.gnt", 32'(tile_gnt), 32'h0);
        chk("t2.g1.cur", 32'(cur_tile), 32'h3);
        chk("t2.g1.uo", 32'(uo_out), 32'h0);
        tick();
        chk("t2.g2.uo", 32'(uo_out), 32'h0);
        tick();
        chk("t2.act.gnt", 32'(tile_gnt), 32'h8);
        chk("t2.act.pulse", 32'(switch_pulse), 32'h1);

        // 3: manual load to tile 2, held with auto off
        auto_en = 1'b0;
        man_sel = 2'd2;
        man_load = 1'b1;
        tick();
        man_load = 1'b0;
        chk("t3.g.cur", 32'(cur_tile), 32'h2);
        chk("t3.g.gnt", 32'(tile_gnt), 32'h0);
        tick();
        tick();
        chk("t3.act.gnt", 32'(tile_gnt), 32'h4);
        tile_req = 4'b1111;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("t3.hold%0d", i), 32'(tile_gnt), 32'h4);
        end

        // 5: pin routing for tile 2
        tile_uo = 32'h00A50000;
        ui_in = 8'h3C;
        #1;
        chk("t5.tile_ui", tile_ui, 32'h003C0000);
        tick();
        chk("t5.uo", 32'(uo_out), 32'hA5);

        // 4: retarget during the 2nd guard cycle restarts the guard
        man_sel = 2'd1;
        man_load = 1'b1;
        tick();
        man_load = 1'b0;
        chk("t4.g1.cur", 32'(cur_tile), 32'h1);
        chk("t4.g1.gnt", 32'(tile_gnt), 32'h0);
        tick();
        chk("t4.g2.gnt", 32'(tile_gnt), 32'h0);
        man_sel = 2'd3;
        man_load = 1'b1;
        tick();
        man_load = 1'b0;
        chk("t4.rs.cur", 32'(cur_tile), 32'h3);
        chk("t4.rs.gnt", 32'(tile_gnt), 32'h0);
        tick();
        chk("t4.rs2.gnt", 32'(tile_gnt), 32'h0);
        tick();
        chk("t4.act.gnt", 32'(tile_gnt), 32'h8);
        chk("t4.act.pulse", 32'(switch_pulse), 32'h1);

        // 6: asynchronous reset while ACTIVE
        tile_uo = 32'h77000000;
        tick();
        chk("t6.uo", 32'(uo_out), 32'h77);
        #3 rst = 1'b1;
        #1;
        chk("t6.async.gnt", 32'(tile_gnt), 32'h0);
        chk("t6.async.uo", 32'(uo_out), 32'h0);
        chk("t6.async.cur", 32'(cur_tile), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("t6.idle.gnt", 32'(tile_gnt), 32'h0);
        chk("t6.idle.cur", 32'(cur_tile), 32'h0);

        // Dwell saturates with a lone requester; a new requester rotates at once
        auto_en = 1'b1;
        tile_req = 4'b0001;
        do_reset();
        repeat (3) tick();
        chk("sat.act.gnt", 32'(tile_gnt), 32'h1);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk($sformatf("sat.hold%0d", i), 32'(tile_gnt), 32'h1);
        end
        tile_req = 4'b0011;
        tick();
        chk("sat.rot.gnt", 32'(tile_gnt), 32'h0);
        chk("sat.rot.cur", 32'(cur_tile), 32'h1);

        // Table-driven per-cycle vectors
        auto_en = 1'b0;
        tile_req = 4'b0000;
        man_load = 1'b0;
        tile_uo = 32'h13121110;
        ui_in = 8'h5A;
        do_reset();
        for (int v = 0; v < 13; v++) begin
            auto_en  = tbl[v].auto_en;
            tile_req = tbl[v].req;
            man_sel  = tbl[v].sel;
            man_load = tbl[v].load;
            tick();
            chk($sformatf("vec%0d.gnt", v), 32'(tile_gnt), 32'(tbl[v].gnt));
            chk($sformatf("vec%0d.cur", v), 32'(cur_tile), 32'(tbl[v].cur));
            chk($sformatf("vec%0d.pulse", v), 32'(switch_pulse), 32'(tbl[v].pulse));
            chk($sformatf("vec%0d.uo", v), 32'(uo_out), 32'(tbl[v].uo));
            chk($sformatf("vec%0d.tile_ui", v), tile_ui, tbl[v].tui);
        end
        man_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
